// File: rtl/adder_mon_pkg.sv
// adder_mon_pkg: shared state encoding, widths and golden-sum helper
// for the adder settle monitor.
package adder_mon_pkg;

  typedef enum logic [1:0] {IDLE, OBSERVE, CLOSE} state_e;

  localparam int DEF_WIDTH = 3;
  localparam int VEC_W     = 2*DEF_WIDTH+1;

  function automatic int unsigned golden_sum(
    input int unsigned a,
    input int unsigned b,
    input logic        c0
  );
    return a + b + {31'b0, c0};
  endfunction

endpackage

// File: rtl/adder_mon_edge_tracker.sv
// adder_mon_edge_tracker: window cycle counter, sampled-output register
// and last-change capture for one observed output group.
module adder_mon_edge_tracker #(
  parameter int SW    = 4,
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [SW-1:0]    dut_sum,
  output logic [DLY_W-1:0] cnt,
  output logic [DLY_W-1:0] chg_nxt
);

  logic [SW-1:0]    d_q;
  logic [DLY_W-1:0] last_chg;

  // value last_chg takes at this edge; the report uses it at window end
  assign chg_nxt = (dut_sum != d_q) ? cnt + DLY_W'(1) : last_chg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      last_chg <= '0;
      d_q      <= '0;
    end else if (start) begin
      cnt      <= '0;
      last_chg <= '0;
      d_q      <= dut_sum;
    end else if (run) begin
      cnt      <= cnt + DLY_W'(1);
      last_chg <= chg_nxt;
      d_q      <= dut_sum;
    end
  end

endmodule

// File: rtl/adder_settle_monitor.sv
// adder_settle_monitor: settle-delay and result checker for an adder.
// Define ADDER_MON_FIRST_FAIL_EN to add first-failure capture ports.
module adder_settle_monitor
  import adder_mon_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WINDOW = 100,
  parameter int DLY_W  = 8,
  parameter int ERR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               c0,
  input  logic [WIDTH:0]     dut_sum,
  output logic               res_valid,
  output logic [DLY_W-1:0]   last_delay,
  output logic               last_ok,
  output logic [DLY_W-1:0]   max_delay,
  output logic [2*WIDTH:0]   max_from,
  output logic [2*WIDTH:0]   max_to,
  output logic [ERR_W-1:0]   mismatch_cnt,
  output logic               err
`ifdef ADDER_MON_FIRST_FAIL_EN
  ,
  output logic [2*WIDTH:0]   fail_vec,
  output logic [WIDTH:0]     fail_got,
  output logic [WIDTH:0]     fail_exp
`endif
);

  localparam int VW = VEC_W + 2*(WIDTH-DEF_WIDTH);
  localparam int SW = WIDTH+1;
  localparam logic [DLY_W-1:0] CNT_END = DLY_W'(WINDOW-2);

  state_e state, state_n;
  logic busy, busy_n, win_end, rpt_ok;
  logic [VW-1:0] in_vec, cur_vec, from_vec, prev_vec;
  logic [VW-1:0] rpt_from, rpt_to;
  logic [SW-1:0] golden, golden_n, rpt_got, rpt_exp;
  logic [DLY_W-1:0] cnt, chg_nxt, rpt_delay;

  assign in_vec   = {a, b, c0};
  assign golden_n = SW'(golden_sum(32'(a), 32'(b), c0));

  // a new vector always starts a window; a running one ends on it
  assign win_end = busy && (in_valid || cnt == CNT_END);
  assign busy_n  = in_valid || (busy && !win_end);
  assign rpt_ok  = rpt_got == rpt_exp;

  assign last_delay = res_valid ? rpt_delay : '0;
  assign last_ok    = res_valid && rpt_ok;

  adder_mon_edge_tracker #(
    .SW    (SW),
    .DLY_W (DLY_W)
  ) u_track (
    .clk     (clk),
    .rst     (rst),
    .start   (in_valid),
    .run     (busy),
    .dut_sum (dut_sum),
    .cnt     (cnt),
    .chg_nxt (chg_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = IDLE;
    res_valid = (state == CLOSE);
    unique case (1'b1)
      win_end:             state_n = CLOSE;
      busy_n && !win_end:  state_n = OBSERVE;
      default:             state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      cur_vec      <= '0;
      from_vec     <= '0;
      prev_vec     <= '0;
      golden       <= '0;
      rpt_delay    <= '0;
      rpt_got      <= '0;
      rpt_exp      <= '0;
      rpt_from     <= '0;
      rpt_to       <= '0;
      max_delay    <= '0;
      max_from     <= '0;
      max_to       <= '0;
      mismatch_cnt <= '0;
      err          <= 1'b0;
    end else begin
      busy <= busy_n;
      if (in_valid) begin
        cur_vec  <= in_vec;
        from_vec <= prev_vec;
        prev_vec <= in_vec;
        golden   <= golden_n;
      end
      // freeze the closing window so the next one can start at once
      if (win_end) begin
        rpt_delay <= chg_nxt;
        rpt_got   <= dut_sum;
        rpt_exp   <= golden;
        rpt_from  <= from_vec;
        rpt_to    <= cur_vec;
      end
      if (res_valid) begin
        if (!rpt_ok) begin
          err <= 1'b1;
          if (mismatch_cnt != '1)
            mismatch_cnt <= mismatch_cnt + ERR_W'(1);
        end
        if (rpt_delay > max_delay) begin
          max_delay <= rpt_delay;
          max_from  <= rpt_from;
          max_to    <= rpt_to;
        end
      end
    end
  end

`ifdef ADDER_MON_FIRST_FAIL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_vec <= '0;
      fail_got <= '0;
      fail_exp <= '0;
    end else if (res_valid && !rpt_ok && !err) begin
      fail_vec <= rpt_to;
      fail_got <= rpt_got;
      fail_exp <= rpt_exp;
    end
  end
`endif

endmodule
